// File: rtl/elevator_pkg.sv
// elevator_pkg: shared FSM states, floor width, direction constants and default floor count
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, SELECT, DISPATCH, WAIT} state_t;
  localparam int FLOOR_W = 4;
  localparam int DEFAULT_N_FLOORS = 16;
  localparam logic UP = 1'b1;
  localparam logic DOWN = 1'b0;
endpackage

// File: rtl/floor_picker.sv
// floor_picker: SCAN target choice; in pending/cur_floor/dir_up, out found/next_floor/next_dir
module floor_picker
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEFAULT_N_FLOORS
) (
  input  logic [15:0]        pending,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               dir_up,
  output logic               found,
  output logic [FLOOR_W-1:0] next_floor,
  output logic               next_dir
);
  logic lo_hit, hi_hit;
  logic [FLOOR_W-1:0] lo_floor, hi_floor;
  always_comb begin
    lo_hit = 1'b0;
    lo_floor = '0;
    hi_hit = 1'b0;
    hi_floor = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (pending[i] && FLOOR_W'(i) >= cur_floor) begin
        lo_hit = 1'b1;
        lo_floor = FLOOR_W'(i);
      end
    for (int i = 0; i < N_FLOORS; i++)
      if (pending[i] && FLOOR_W'(i) <= cur_floor) begin
        hi_hit = 1'b1;
        hi_floor = FLOOR_W'(i);
      end
    found = lo_hit | hi_hit;
    next_dir = dir_up ? (lo_hit ? UP : DOWN) : (hi_hit ? DOWN : UP);
    next_floor = dir_up ? (lo_hit ? lo_floor : hi_floor) : (hi_hit ? hi_floor : lo_floor);
  end
endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: latches floor calls, picks SCAN targets, dispatches via tgt_valid/tgt_ready, clears on door_open, sticky fault on arrival timeout
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEFAULT_N_FLOORS,
  parameter int ARRIVE_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               on,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               door_open,
  input  logic               tgt_ready,
  output logic               tgt_valid,
  output logic [FLOOR_W-1:0] target_floor,
  output logic               dir_up,
  output logic [15:0]        pending,
  output logic               busy,
  output logic               fault
);
  localparam int WD_W = $clog2(ARRIVE_TIMEOUT + 1);
  state_t state, state_n;
  logic [WD_W-1:0] wd;
  logic pick_found, pick_dir, req_ok, arrive, timeout;
  logic [FLOOR_W-1:0] pick_floor;
  logic [15:0] set_mask, clr_mask;
  floor_picker #(.N_FLOORS(N_FLOORS)) u_picker (
    .pending(pending),
    .cur_floor(cur_floor),
    .dir_up(dir_up),
    .found(pick_found),
    .next_floor(pick_floor),
    .next_dir(pick_dir)
  );
  assign req_ok = req_valid && (32'(req_floor) < N_FLOORS);
  assign set_mask = req_ok ? 16'(1) << req_floor : '0;
  assign arrive = state == WAIT && door_open && cur_floor == target_floor;
  assign clr_mask = arrive ? 16'(1) << target_floor : '0;
  assign timeout = state == WAIT && wd == WD_W'(ARRIVE_TIMEOUT - 1);
  always_comb begin
    tgt_valid = state == DISPATCH;
    busy = state != IDLE;
    state_n = state == IDLE ? ((on && !fault && |pending) ? SELECT : IDLE) :
              state == SELECT ? DISPATCH :
              state == DISPATCH ? (tgt_ready ? WAIT : (!on ? IDLE : DISPATCH)) :
              ((arrive || timeout) ? IDLE : WAIT);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      pending <= '0;
      dir_up <= UP;
      target_floor <= '0;
      wd <= '0;
      fault <= 1'b0;
    end else begin
      pending <= (pending | set_mask) & ~clr_mask;
      if (state == SELECT && pick_found) begin
        target_floor <= pick_floor;
        dir_up <= pick_dir;
      end
      wd <= state == WAIT ? wd + 1'b1 : '0;
      if (timeout && !arrive) fault <= 1'b1;
    end
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios plus randomized car traffic checked against a behavioural scheduler model
module tb_elevator_scheduler;
  localparam int P_IDLE = 0, P_SEL = 1, P_DISP = 2, P_WAIT = 3;
  logic clk = 1'b0;
  logic reset = 1'b1, on = 1'b0, req_valid = 1'b0, door_open = 1'b0, tgt_ready = 1'b0;
  logic [3:0] req_floor = '0, cur_floor = '0;
  logic tgt_valid, dir_up, busy, fault;
  logic [3:0] target_floor;
  logic [15:0] pending;
  int tests = 0, fails = 0;
  int m_ph = P_IDLE, m_tgt = 0, m_wcnt = 0;
  bit [15:0] m_pend = '0;
  bit m_dir = 1'b1, m_fault = 1'b0;
  elevator_scheduler dut (
    .clk(clk), .reset(reset), .on(on), .req_valid(req_valid), .req_floor(req_floor),
    .cur_floor(cur_floor), .door_open(door_open), .tgt_ready(tgt_ready),
    .tgt_valid(tgt_valid), .target_floor(target_floor), .dir_up(dir_up),
    .pending(pending), .busy(busy), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void pick(input bit [15:0] p, input int cur, input bit d, output int t, output bit nd);
    int up_ge = -1, dn_le = -1, up_gt = -1, dn_lt = -1;
    for (int f = 0; f < 16; f++)
      if (p[f]) begin
        if (f >= cur && up_ge < 0) up_ge = f;
        if (f > cur && up_gt < 0) up_gt = f;
        if (f <= cur) dn_le = f;
        if (f < cur) dn_lt = f;
      end
    if (d) begin
      t = up_ge >= 0 ? up_ge : dn_lt;
      nd = up_ge >= 0;
    end else begin
      t = dn_le >= 0 ? dn_le : up_gt;
      nd = dn_le < 0;
    end
  endfunction
  task automatic cycle();
    int ph = m_ph;
    bit [15:0] np = m_pend;
    int t;
    bit d;
    if (reset) begin
      ph = P_IDLE; np = '0; m_dir = 1'b1; m_tgt = 0; m_fault = 1'b0; m_wcnt = 0;
    end else begin
      if (req_valid && int'(req_floor) < 16) np[req_floor] = 1'b1;
      if (m_ph == P_IDLE) begin
        if (on && !m_fault && m_pend != 0) ph = P_SEL;
      end else if (m_ph == P_SEL) begin
        pick(m_pend, int'(cur_floor), m_dir, t, d);
        m_tgt = t; m_dir = d; ph = P_DISP;
      end else if (m_ph == P_DISP) begin
        if (tgt_ready) begin ph = P_WAIT; m_wcnt = 0; end
        else if (!on) ph = P_IDLE;
      end else begin
        m_wcnt++;
        if (door_open && int'(cur_floor) == m_tgt) begin np[m_tgt] = 1'b0; ph = P_IDLE; end
        else if (m_wcnt == 255) begin m_fault = 1'b1; ph = P_IDLE; end
      end
    end
    @(posedge clk);
    #1;
    m_ph = ph;
    m_pend = np;
    check("pending", pending, m_pend);
    check("tgt_valid", 16'(tgt_valid), 16'(m_ph == P_DISP));
    check("busy", 16'(busy), 16'(m_ph != P_IDLE));
    check("fault", 16'(fault), 16'(m_fault));
    check("dir_up", 16'(dir_up), 16'(m_dir));
    check("target", 16'(target_floor), 16'(m_tgt));
  endtask
  task automatic request(input int f);
    req_valid = 1'b1;
    req_floor = 4'(f);
    cycle();
    req_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!tgt_valid && n < 50) begin cycle(); n++; end
    check("dispatch_seen", 16'(tgt_valid), 16'(1));
  endtask
  task automatic serve(input int exp_tgt, input bit exp_dir, input int hold);
    tgt_ready = 1'b0;
    door_open = 1'b0;
    wait_valid();
    check("dispatch_tgt", 16'(target_floor), 16'(exp_tgt));
    check("dispatch_dir", 16'(dir_up), 16'(exp_dir));
    repeat (hold) cycle();
    tgt_ready = 1'b1;
    cycle();
    tgt_ready = 1'b0;
    while (cur_floor != 4'(exp_tgt)) begin
      cur_floor = cur_floor < 4'(exp_tgt) ? cur_floor + 4'd1 : cur_floor - 4'd1;
      cycle();
    end
    door_open = 1'b1;
    cycle();
    door_open = 1'b0;
  endtask
  initial begin
    int n;
    bit car_busy = 1'b0;
    logic [3:0] car_tgt = '0;
    cycle();
    reset = 1'b0;
    on = 1'b1;
    cur_floor = 4'd2;
    request(4);
    request(9);
    serve(4, 1'b1, 0);
    serve(9, 1'b1, 0);
    check("sweep_pending_empty", pending, 16'h0000);
    check("sweep_dir_up", 16'(dir_up), 16'(1));
    cur_floor = 4'd7;
    request(3);
    serve(3, 1'b0, 2);
    cur_floor = 4'd5;
    request(5);
    serve(5, 1'b0, 0);
    check("in_place_idle", 16'(busy), 16'(0));
    request(10);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("stall_valid", 16'(tgt_valid), 16'(1));
      check("stall_tgt", 16'(target_floor), 16'(10));
    end
    on = 1'b0;
    cycle();
    check("abort_valid", 16'(tgt_valid), 16'(0));
    check("abort_keeps_bit", 16'(pending[10]), 16'(1));
    on = 1'b1;
    serve(10, 1'b1, 0);
    cur_floor = 4'd6;
    request(6);
    wait_valid();
    tgt_ready = 1'b1;
    cycle();
    tgt_ready = 1'b0;
    door_open = 1'b1;
    req_valid = 1'b1;
    req_floor = 4'd6;
    cycle();
    door_open = 1'b0;
    check("clear_wins", 16'(pending[6]), 16'(0));
    cycle();
    req_valid = 1'b0;
    check("recall_sets", 16'(pending[6]), 16'(1));
    serve(6, 1'b1, 0);
    request(8);
    wait_valid();
    check("fault_trip_tgt", 16'(target_floor), 16'(8));
    tgt_ready = 1'b1;
    cycle();
    tgt_ready = 1'b0;
    n = 0;
    while (!fault && n < 300) begin cycle(); n++; end
    check("fault_latency", 16'(n), 16'(255));
    request(2);
    repeat (20) cycle();
    check("fault_no_dispatch", 16'(busy), 16'(0));
    check("fault_latched_calls", pending, 16'h0104);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("reset_clears_fault", 16'(fault), 16'(0));
    for (int c = 0; c < 3000; c++) begin
      reset = c == 1500;
      if (reset) car_busy = 1'b0;
      req_valid = $urandom_range(0, 3) == 0;
      req_floor = 4'($urandom_range(0, 15));
      on = $urandom_range(0, 19) != 0;
      door_open = 1'b0;
      if (car_busy) begin
        if (cur_floor == car_tgt) begin
          door_open = 1'b1;
          car_busy = 1'b0;
        end else if ($urandom_range(0, 1) == 1)
          cur_floor = cur_floor < car_tgt ? cur_floor + 4'd1 : cur_floor - 4'd1;
      end
      tgt_ready = !car_busy && $urandom_range(0, 2) != 0;
      if (tgt_valid && tgt_ready) begin
        car_busy = 1'b1;
        car_tgt = target_floor;
      end
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
